// File: rtl/weight_stream_reader_pkg.sv
// Shared definitions for the weight stream reader and the weight BRAMs:
// default geometry, FSM state encoding and the read-credit helper.
package weight_stream_reader_pkg;

    localparam int WSR_DEPTH = 28;
    localparam int WSR_AW    = 5;
    localparam int WSR_DW    = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } wsr_state_t;

    // A new read may be issued only while the words already owned by the
    // reader (buffered after this edge's pop, plus the one in flight) leave
    // room in the 2-entry buffer.
    function automatic logic credit_ok(input logic [1:0] count,
                                       input logic       pop,
                                       input logic       inflight);
        logic [2:0] occ;
        occ = {1'b0, count} - {2'b00, pop} + {2'b00, inflight};
        return (occ < 3'd2);
    endfunction

endpackage

// File: rtl/weight_stream_reader_if.sv
// Bus bundle between the weight stream reader, its BRAM port and the MAC
// consumer. master = reader side, slave = BRAM model + consumer side.
interface weight_stream_reader_if
    import weight_stream_reader_pkg::*;
#(
    parameter int AW = WSR_AW,
    parameter int DW = WSR_DW
);
    logic [AW-1:0] bram_addr;
    logic          bram_en;
    logic          bram_we;
    logic [DW-1:0] bram_do;
    logic [DW-1:0] w_data;
    logic [AW-1:0] w_index;
    logic          w_valid;
    logic          w_ready;
    logic          w_last;

    modport master (
        output bram_addr, bram_en, bram_we,
        input  bram_do,
        output w_data, w_index, w_valid, w_last,
        input  w_ready
    );

    modport slave (
        input  bram_addr, bram_en, bram_we,
        output bram_do,
        input  w_data, w_index, w_valid, w_last,
        output w_ready
    );
endinterface

// File: rtl/weight_skid_buffer.sv
// Two-entry FIFO holding {last, index, data} beats. Slot 0 is always the
// head, so the head outputs come straight from flops. When the buffer
// empties, slot 0 is cleared so the head payload reads back as zero.
module weight_skid_buffer
    import weight_stream_reader_pkg::*;
#(
    parameter int W = 22
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic         head_valid,
    output logic [1:0]   count
);
    logic [W-1:0] slot0_r;
    logic [W-1:0] slot1_r;
    logic         v0_r;
    logic         v1_r;
    logic         pop_ok_s;
    logic         push_ok_s;

    assign pop_ok_s   = pop & v0_r;
    assign push_ok_s  = push & (~(v0_r & v1_r) | pop_ok_s);
    assign head_data  = slot0_r;
    assign head_valid = v0_r;
    assign count      = {1'b0, v0_r} + {1'b0, v1_r};

    // Storage update: flush wins, otherwise push/pop shift the two slots.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot0_r <= {W{1'b0}};
            slot1_r <= {W{1'b0}};
            v0_r    <= 1'b0;
            v1_r    <= 1'b0;
        end else if (flush) begin
            slot0_r <= {W{1'b0}};
            slot1_r <= {W{1'b0}};
            v0_r    <= 1'b0;
            v1_r    <= 1'b0;
        end else begin
            case ({push_ok_s, pop_ok_s})
                2'b10: begin
                    if (!v0_r) begin
                        slot0_r <= push_data;
                        v0_r    <= 1'b1;
                    end else begin
                        slot1_r <= push_data;
                        v1_r    <= 1'b1;
                    end
                end
                2'b01: begin
                    if (v1_r) begin
                        slot0_r <= slot1_r;
                        v1_r    <= 1'b0;
                    end else begin
                        slot0_r <= {W{1'b0}};
                        v0_r    <= 1'b0;
                    end
                end
                2'b11: begin
                    if (v1_r) begin
                        slot0_r <= slot1_r;
                        slot1_r <= push_data;
                    end else begin
                        slot0_r <= push_data;
                    end
                end
                default: begin
                    slot0_r <= slot0_r;
                end
            endcase
        end
    end
endmodule

// File: rtl/weight_stream_reader.sv
// Weight stream reader: walks one neuron's weight BRAM from address 0 to
// DEPTH-1 and hands the words to the MAC as a valid/ready stream.
// Reads are credit-limited so the 2-entry buffer can absorb any stall.
// Optional build macro WEIGHT_STREAM_ABORT_EN adds an ABORT input that
// cancels a running stream without a DONE pulse.
module weight_stream_reader
    import weight_stream_reader_pkg::*;
#(
    parameter int DEPTH = WSR_DEPTH,
    parameter int AW    = WSR_AW,
    parameter int DW    = WSR_DW
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
`ifdef WEIGHT_STREAM_ABORT_EN
    input  logic abort,
`endif
    output logic busy,
    output logic done,
    weight_stream_reader_if.master bus
);
    localparam int            PW        = 1 + AW + DW;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    wsr_state_t    state_r;
    logic [AW-1:0] bram_addr_r;
    logic          bram_en_r;
    logic          inflight_r;
    logic          busy_r;
    logic          done_r;

    logic [PW-1:0] push_payload_s;
    logic [PW-1:0] head_s;
    logic          head_valid_s;
    logic [1:0]    count_s;
    logic          pop_s;
    logic          abort_s;
    logic          issue_ok_s;
    logic [AW-1:0] next_addr_s;

`ifdef WEIGHT_STREAM_ABORT_EN
    assign abort_s = abort & busy_r;
`else
    assign abort_s = 1'b0;
`endif

    // The word returning this cycle belongs to the address still on the port.
    assign push_payload_s = {(bram_addr_r == LAST_ADDR), bram_addr_r, bus.bram_do};
    assign pop_s          = head_valid_s & bus.w_ready;
    assign issue_ok_s     = credit_ok(count_s, pop_s, inflight_r);
    assign next_addr_s    = bram_addr_r + AW'(1);

    weight_skid_buffer #(
        .W (PW)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .flush      (abort_s),
        .push       (inflight_r),
        .push_data  (push_payload_s),
        .pop        (pop_s),
        .head_data  (head_s),
        .head_valid (head_valid_s),
        .count      (count_s)
    );

    // Sequencer: issues reads in address order and reports completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            bram_addr_r <= {AW{1'b0}};
            bram_en_r   <= 1'b0;
            inflight_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else if (abort_s) begin
            state_r    <= ST_IDLE;
            bram_en_r  <= 1'b0;
            inflight_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    // A START coinciding with the DONE pulse is dropped.
                    if (start && !done_r) begin
                        bram_en_r   <= 1'b1;
                        bram_addr_r <= {AW{1'b0}};
                        inflight_r  <= 1'b1;
                        busy_r      <= 1'b1;
                        state_r     <= (LAST_ADDR == {AW{1'b0}}) ? ST_DRAIN : ST_STREAM;
                    end else begin
                        bram_en_r  <= 1'b0;
                        inflight_r <= 1'b0;
                    end
                end
                ST_STREAM: begin
                    if (issue_ok_s) begin
                        bram_en_r   <= 1'b1;
                        bram_addr_r <= next_addr_s;
                        inflight_r  <= 1'b1;
                        if (next_addr_s == LAST_ADDR) begin
                            state_r <= ST_DRAIN;
                        end else begin
                            state_r <= ST_STREAM;
                        end
                    end else begin
                        bram_en_r  <= 1'b0;
                        inflight_r <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    bram_en_r  <= 1'b0;
                    inflight_r <= 1'b0;
                    // The last word is issued last, so its transfer empties everything.
                    if (pop_s && head_s[PW-1]) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    bram_en_r  <= 1'b0;
                    inflight_r <= 1'b0;
                    busy_r     <= 1'b0;
                    done_r     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.bram_addr = bram_addr_r;
    assign bus.bram_en   = bram_en_r;
    assign bus.bram_we   = 1'b0;
    assign bus.w_data    = head_s[DW-1:0];
    assign bus.w_index   = head_s[PW-2 -: AW];
    assign bus.w_last    = head_s[PW-1];
    assign bus.w_valid   = head_valid_s;
    assign busy          = busy_r;
    assign done          = done_r;
endmodule

// File: doc/weight_stream_reader.md
Name: weight_stream_reader

Overview:
- Read-side master for one single-port neuron weight BRAM: fetches all DEPTH weights in address order.
- Drives ADDR/EN/WE on the BRAM port and captures DO.
- Presents the weights to the neuron MAC datapath as a valid/ready stream, with backpressure absorbed by a 2-entry output buffer.
- Sits between each weight BRAM instance and its MAC unit in the ANN layer.

Parameters:
- DEPTH, 28, number of weights per neuron (BRAM words 0..DEPTH-1).
- AW, 5, BRAM address width; must satisfy 2^AW >= DEPTH.
- DW, 16, weight word width.

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  one-cycle request to stream all weights; ignored while BUSY=1.
- BRAM_ADDR  out  AW  BRAM address, registered.
- BRAM_EN  out  1  BRAM enable, registered.
- BRAM_WE  out  1  constant 0; this block never writes.
- BRAM_DO  in  DW  BRAM read data. BRAM samples on negedge CLK, so data is stable before the next posedge.
- W_DATA  out  DW  weight word at buffer head.
- W_INDEX  out  AW  address of W_DATA.
- W_VALID  out  1  buffer head valid.
- W_READY  in  1  consumer accepts; a transfer occurs on a posedge with W_VALID and W_READY both high.
- W_LAST  out  1  high with W_VALID when W_INDEX = DEPTH-1.
- BUSY  out  1  high from the cycle after START is accepted until DONE.
- DONE  out  1  one-cycle pulse after the final transfer.

Behaviour:
- Reset:
  - state=IDLE; BRAM_EN=0, BRAM_ADDR=0, BRAM_WE=0.
  - Buffer empty, in-flight flag clear.
  - W_VALID=0, W_LAST=0, W_DATA=0, W_INDEX=0, BUSY=0, DONE=0.
  - Reset asserted mid-stream aborts immediately: no further BRAM_EN, no DONE.
- Read timing:
  - A read issued with BRAM_EN=1 / BRAM_ADDR=a after posedge k is captured from BRAM_DO at posedge k+1.
  - Captured data goes into the buffer tail with index a. Read latency is 1 cycle.
- Credit rule: issue a read only if (buffer count + in-flight) < 2. This keeps the buffer from overflowing.
  - When the buffer pops and a capture lands in the same cycle, count is unchanged.
- Throughput: with W_READY held high, one transfer per cycle.
- FSM:
  - IDLE: START=1 -> STREAM; issue read addr 0 in the same edge.
  - STREAM: issue sequential reads while credit allows. After issuing addr DEPTH-1 -> DRAIN; BRAM_EN=0 the next cycle.
  - DRAIN: when buffer empty and nothing in flight, following the transfer with W_LAST -> IDLE, DONE=1 for one cycle.
- BRAM_EN is low on every cycle where no read is issued. BRAM_ADDR holds its last value when idle.
- Address never wraps past DEPTH-1. DEPTH not a power of two is legal.
- START while BUSY: ignored, no restart.
- START in the same cycle as DONE: ignored. A new START is accepted from the cycle after DONE.
- W_DATA/W_INDEX/W_LAST hold stable while W_VALID=1 and W_READY=0.

Optional Feature:
- Macro: WEIGHT_STREAM_ABORT_EN.
- With the macro defined: extra input ABORT (1 bit). When ABORT=1 on a posedge while BUSY:
  - Flush the buffer and drop any in-flight capture.
  - BRAM_EN=0, W_VALID=0.
  - Go to IDLE with no DONE pulse.
  - ABORT outranks a simultaneous transfer, and the transfer does not count.
- Without the macro: no ABORT port; only RST stops a stream.

Decomposition:
- Shared package: FSM state encoding (IDLE, STREAM, DRAIN) and default DEPTH/AW/DW constants, also used by the BRAM instances.
- One sub-module: weight_skid_buffer, a 2-entry FIFO of {index, data}.
  - Ports: push, pop, full/count, head outputs.
  - Same CLK/RST convention.

Test Plan:
- BRAM preloaded with word i = 16'h0100+i, W_READY=1, START at edge E0:
  - BRAM_EN=1 with ADDR 0..27 after E0..E27.
  - W_VALID after E1; beats 0x0100..0x011B transfer at E2..E29, W_LAST on index 27.
  - DONE pulse after E29, BUSY low with DONE.
- W_READY low for cycles 5-12 mid-stream:
  - At most 2 reads outstanding; BRAM_EN deasserts while stalled.
  - W_DATA held stable; all 28 words arrive in order, no duplicates or losses.
- W_READY toggling 1,0,1,0:
  - 28 transfers in order; DONE only after the index-27 transfer.
- START pulsed again at E10 during a stream and in the DONE cycle:
  - Ignored both times.
  - START one cycle after DONE begins a new identical stream.
- RST asserted at E15 mid-stream:
  - All outputs at reset values immediately (asynchronously); no DONE.
  - START afterwards restarts from addr 0.
- WEIGHT_STREAM_ABORT_EN build, ABORT at E12:
  - W_VALID=0 and BRAM_EN=0 after E12, no DONE, BUSY=0.
  - Next START streams all 28 from addr 0.
